// File: rtl/board_io_ctrl.sv
// Board-side I/O controller: button debounce, CPU clock-enable generation,
// debug register select and an 8-digit multiplexed seven-segment display.
module board_io_ctrl #(
   parameter int SCAN_DIV   = 100000,
   parameter int RUN_DIV    = 50000000,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run_mode,
   input  logic        step_btn,
   input  logic        reg_browse,
   input  logic [4:0]  reg_sel_in,
   input  logic [2:0]  disp_sel,
   input  logic [31:0] pc,
   input  logic [31:0] instr,
   input  logic [31:0] reg_data,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic [31:0] debug_data,
   input  logic        stall_if,
   output logic        cpu_ce,
   output logic [4:0]  reg_sel,
   output logic [31:0] step_cnt,
   output logic [7:0]  an,
   output logic [7:0]  seg
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int RUN_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_DIV - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   logic             btn_sync_p0, btn_sync_p1;
   logic [DEB_W-1:0] deb_cnt;
   logic             deb_lvl, deb_prev, step_req;
   logic [RUN_W-1:0] div_cnt;
   logic [1:0]       mode_prev;
   logic             mode_chg, div_wrap;
   logic [SCAN_W-1:0] scan_cnt;
   logic [2:0]       dig_idx;
   logic [31:0]      shadow, disp_src;

   // Button: synchronizer, debouncer, rising-edge step request
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_sync_p0 <= 1'b0;
         btn_sync_p1 <= 1'b0;
         deb_cnt     <= '0;
         deb_lvl     <= 1'b0;
         deb_prev    <= 1'b0;
         step_req    <= 1'b0;
      end else begin
         btn_sync_p0 <= step_btn;
         btn_sync_p1 <= btn_sync_p0;
         deb_prev    <= deb_lvl;
         step_req    <= deb_lvl & ~deb_prev;
         if (btn_sync_p1 == deb_lvl) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_lvl <= btn_sync_p1;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

   // A mode change restarts the divider and suppresses its wrap in that cycle
   assign mode_chg = ({run_mode, reg_browse} != mode_prev);
   assign div_wrap = (div_cnt == RUN_LAST) && !mode_chg;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         mode_prev <= {run_mode, reg_browse};
      end else begin
         mode_prev <= {run_mode, reg_browse};
         if (mode_chg || div_cnt == RUN_LAST) div_cnt <= '0;
         else                                 div_cnt <= div_cnt + 1'b1;
      end
   end

   always_comb begin
      cpu_ce = 1'b0;
      if (!rst && !reg_browse) cpu_ce = run_mode ? div_wrap : step_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step_cnt <= '0;
         reg_sel  <= '0;
      end else begin
         if (cpu_ce) step_cnt <= step_cnt + 1'b1;
         if (!reg_browse)   reg_sel <= reg_sel_in;
         else if (div_wrap) reg_sel <= reg_sel + 1'b1;
      end
   end

   // Display: source mux, frame-latched shadow, digit scan and segment drive
   always_comb begin
      disp_src = pc;
      case (disp_sel)
         3'd0: disp_src = pc;
         3'd1: disp_src = instr;
         3'd2: disp_src = reg_data;
         3'd3: disp_src = mem_addr;
         3'd4: disp_src = mem_data;
         3'd5: disp_src = debug_data;
         3'd6: disp_src = {27'b0, reg_sel};
         default: disp_src = step_cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         dig_idx  <= '0;
         shadow   <= '0;
         an       <= 8'hFE;
         seg      <= 8'hC0;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            dig_idx  <= dig_idx + 1'b1;
            if (dig_idx == 3'd7) shadow <= disp_src;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         an  <= ~(8'd1 << dig_idx);
         seg <= {~(stall_if && dig_idx == 3'd0), hex7(shadow[{dig_idx, 2'b00} +: 4])};
      end
   end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with small divider/debounce parameters.
module tb_board_io_ctrl;
   localparam int SCAN_DIV   = 4;
   localparam int RUN_DIV    = 10;
   localparam int DEB_CYCLES = 5;

   logic        clk = 1'b0;
   logic        rst, run_mode, step_btn, reg_browse, stall_if;
   logic [4:0]  reg_sel_in;
   logic [2:0]  disp_sel;
   logic [31:0] pc, instr, reg_data, mem_addr, mem_data, debug_data;
   logic        cpu_ce;
   logic [4:0]  reg_sel;
   logic [31:0] step_cnt;
   logic [7:0]  an, seg;

   always #5 clk = ~clk;

   board_io_ctrl #(.SCAN_DIV(SCAN_DIV), .RUN_DIV(RUN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
      .clk(clk), .rst(rst), .run_mode(run_mode), .step_btn(step_btn),
      .reg_browse(reg_browse), .reg_sel_in(reg_sel_in), .disp_sel(disp_sel),
      .pc(pc), .instr(instr), .reg_data(reg_data), .mem_addr(mem_addr),
      .mem_data(mem_data), .debug_data(debug_data), .stall_if(stall_if),
      .cpu_ce(cpu_ce), .reg_sel(reg_sel), .step_cnt(step_cnt), .an(an), .seg(seg)
   );

   typedef struct {
      logic [2:0]  sel;
      logic [31:0] val;
   } disp_vec_t;

   disp_vec_t  vecs [8];
   logic [6:0] hex_pat [16];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_an(input logic [7:0] target, input int budget);
      int n = 0;
      while (an !== target && n < budget) begin
         tick();
         n++;
      end
      chk("wait_an", {24'b0, an}, {24'b0, target});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_cpu_ce"}, {31'b0, cpu_ce}, 32'd0);
      chk({tag, "_reg_sel"}, {27'b0, reg_sel}, 32'd0);
      chk({tag, "_step_cnt"}, step_cnt, 32'd0);
      chk({tag, "_an"}, {24'b0, an}, 32'hFE);
      chk({tag, "_seg"}, {24'b0, seg}, 32'hC0);
   endtask

   initial begin
      int ce_hits;
      int ce_pairs;
      logic prev_ce;
      logic [31:0] val;
      int d;

      hex_pat[0]  = 7'b1000000; hex_pat[1]  = 7'b1111001; hex_pat[2]  = 7'b0100100;
      hex_pat[3]  = 7'b0110000; hex_pat[4]  = 7'b0011001; hex_pat[5]  = 7'b0010010;
      hex_pat[6]  = 7'b0000010; hex_pat[7]  = 7'b1111000; hex_pat[8]  = 7'b0000000;
      hex_pat[9]  = 7'b0010000; hex_pat[10] = 7'b0001000; hex_pat[11] = 7'b0000011;
      hex_pat[12] = 7'b1000110; hex_pat[13] = 7'b0100001; hex_pat[14] = 7'b0000110;
      hex_pat[15] = 7'b0001110;

      pc = 32'h0040_00A4; instr = 32'h1234_5678; reg_data = 32'h9ABC_DEF0;
      mem_addr = 32'h0BAD_F00D; mem_data = 32'hCAFE_1234; debug_data = 32'h5A5A_C3C3;
      // step_cnt is 11 and reg_sel is 0x1B by the time the display table runs
      vecs[0] = '{3'd0, 32'h0040_00A4}; vecs[1] = '{3'd1, 32'h1234_5678};
      vecs[2] = '{3'd2, 32'h9ABC_DEF0}; vecs[3] = '{3'd3, 32'h0BAD_F00D};
      vecs[4] = '{3'd4, 32'hCAFE_1234}; vecs[5] = '{3'd5, 32'h5A5A_C3C3};
      vecs[6] = '{3'd6, 32'h0000_001B}; vecs[7] = '{3'd7, 32'h0000_000B};

      rst = 1'b1; run_mode = 1'b1; step_btn = 1'b0; reg_browse = 1'b0;
      stall_if = 1'b0; reg_sel_in = 5'd0; disp_sel = 3'd0;

      // Reset hold
      repeat (3) tick();
      check_reset_outputs("rst_hold");

      // Free-run from reset: first pulse in cycle 10, then every 10 cycles
      rst = 1'b0;
      ce_hits = 0; ce_pairs = 0; prev_ce = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         if (c <= 9) begin
            chk("fr_early_ce", {31'b0, cpu_ce}, 32'd0);
            chk("fr_early_seg", {24'b0, seg}, 32'hC0);
         end
         if (c <= 4) chk("fr_early_an", {24'b0, an}, 32'hFE);
         if (c <= 10) chk("fr_early_cnt", step_cnt, 32'd0);
         if (c == 10) chk("fr_first_ce", {31'b0, cpu_ce}, 32'd1);
         if (cpu_ce) ce_hits++;
         if (cpu_ce && prev_ce) ce_pairs++;
         prev_ce = cpu_ce;
         tick();
      end
      chk("fr_pulses", ce_hits, 32'd10);
      chk("fr_no_back2back", ce_pairs, 32'd0);
      chk("fr_step_cnt", step_cnt, 32'd10);

      // Register browse: CPU halted, reg_sel advances on each divider wrap
      reg_browse = 1'b1;
      ce_hits = 0;
      for (int n = 1; n <= 330; n++) begin
         tick();
         if (cpu_ce) ce_hits++;
         if ((n - 1) % 10 == 0 || (n - 1) % 10 == 9)
            chk("browse_reg_sel", {27'b0, reg_sel}, ((n - 1) / 10) % 32);
      end
      chk("browse_ce", ce_hits, 32'd0);
      chk("browse_step_cnt", step_cnt, 32'd10);

      // Back to manual select, single-step mode
      reg_browse = 1'b0; run_mode = 1'b0; reg_sel_in = 5'h1B;
      tick();
      chk("manual_reg_sel", {27'b0, reg_sel}, 32'h1B);
      repeat (3) tick();

      // Held press: exactly one pulse, after the 8th edge
      step_btn = 1'b1;
      ce_hits = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (cpu_ce) ce_hits++;
         if (k >= 7 && k <= 9) chk("step_ce_timing", {31'b0, cpu_ce}, (k == 8) ? 32'd1 : 32'd0);
      end
      chk("step_pulses", ce_hits, 32'd1);
      chk("step_cnt_after_press", step_cnt, 32'd11);

      // Release must not pulse
      step_btn = 1'b0;
      ce_hits = 0;
      repeat (20) begin
         tick();
         if (cpu_ce) ce_hits++;
      end
      chk("release_pulses", ce_hits, 32'd0);

      // Bounce 3 high / 2 low: never stable long enough
      ce_hits = 0;
      repeat (4) begin
         step_btn = 1'b1;
         repeat (3) begin tick(); if (cpu_ce) ce_hits++; end
         step_btn = 1'b0;
         repeat (2) begin tick(); if (cpu_ce) ce_hits++; end
      end
      repeat (15) begin tick(); if (cpu_ce) ce_hits++; end
      chk("bounce_pulses", ce_hits, 32'd0);
      chk("bounce_step_cnt", step_cnt, 32'd11);

      // Display sources, one full frame each
      for (int v = 0; v < 8; v++) begin
         disp_sel = vecs[v].sel;
         val = vecs[v].val;
         tick();
         wait_an(8'hFD, 40);
         wait_an(8'hFE, 40);
         for (int k = 0; k < 8; k++) begin
            chk("disp_an", {24'b0, an}, {24'b0, ~(8'd1 << k)});
            chk("disp_seg", {24'b0, seg}, {24'b0, 1'b1, hex_pat[val[4*k +: 4]]});
            if (v == 0 && k == 1) chk("pc_digit1_A", {24'b0, seg}, 32'h88);
            repeat (SCAN_DIV) tick();
         end
      end

      // Stall dp on digit 0 only; mid-frame source change waits for next latch
      disp_sel = 3'd0;
      tick();
      wait_an(8'hFD, 40);
      wait_an(8'hFE, 40);
      stall_if = 1'b1;
      disp_sel = 3'd1;
      for (int t = 1; t <= 32; t++) begin
         tick();
         d = (t / 4) % 8;
         val = (t == 32) ? instr : pc;
         chk("mid_an", {24'b0, an}, {24'b0, ~(8'd1 << d)});
         chk("mid_seg", {25'b0, seg[6:0]}, {25'b0, hex_pat[val[4*d +: 4]]});
         chk("mid_dp", {31'b0, seg[7]}, (d == 0) ? 32'd0 : 32'd1);
      end
      stall_if = 1'b0;

      // Reset in the middle of a debounce
      step_btn = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("rst_deb");
      step_btn = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      ce_hits = 0;
      repeat (15) begin tick(); if (cpu_ce) ce_hits++; end
      chk("rst_deb_no_pulse", ce_hits, 32'd0);

      // Reset in the middle of the free-run divider
      run_mode = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("rst_div");
      ce_hits = 0;
      repeat (2) begin tick(); if (cpu_ce) ce_hits++; end
      chk("rst_div_hold_ce", ce_hits, 32'd0);
      rst = 1'b0;
      ce_hits = 0;
      for (int c = 1; c <= 10; c++) begin
         if (c < 10 && cpu_ce) ce_hits++;
         if (c == 10) chk("rst_div_first_ce", {31'b0, cpu_ce}, 32'd1);
         tick();
      end
      chk("rst_div_early_ce", ce_hits, 32'd0);
      chk("rst_div_step_cnt", step_cnt, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

endmodule
